rectify_sequencer: RTL and testbench
====================================

Name: rectify_sequencer

Overview:
- Initiator side of the corner_detector start/done handshake.
- On each frame_ready it pulses start to the corner detector, waits for done with a timeout, and latches the four corners.
- It sanity-checks the quadrilateral, then launches the rectifier through a second start/done handshake.
- Holds the last good corner set for downstream use and reports errors and dropped frames.

Parameters:
- XW, 10, corner x-coordinate width (640-wide frame).
- YW, 9, corner y-coordinate width (480-tall frame).
- TIMEOUT, 1000000, maximum cycles to wait for any done before aborting.
- MIN_SPAN, 16, minimum edge length in pixels for a valid quadrilateral.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_ready  in  1  one-cycle pulse: a new frame is in memory.
- cd_start  out  1  one-cycle start pulse to corner_detector.
- cd_done  in  1  one-cycle done pulse from corner_detector.
- cd_corners  in  4*(XW+YW)  packed {br_y,br_x,bl_y,bl_x,tr_y,tr_x,tl_y,tl_x}; valid in the cd_done cycle.
- rect_start  out  1  one-cycle start pulse to the rectifier.
- rect_done  in  1  one-cycle done pulse from the rectifier.
- corners  out  4*(XW+YW)  last accepted corner set, same packing.
- busy  out  1  high in every state except IDLE.
- err_code  out  2  0=ok, 1=detector timeout, 2=bad quad, 3=rectifier timeout.
- good_count  out  8  successful rectifications; wraps at 255->0.
- drop_count  out  8  frame_ready pulses ignored while busy; saturates at 255.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; cd_start=0; rect_start=0; busy=0.
  - corners=0; err_code=0; good_count=0; drop_count=0; timer=0.
  - Reset asserted mid-operation aborts immediately. No pulse may extend past reset.
- States: IDLE, START_CD, WAIT_CD, CHECK, START_RECT, WAIT_RECT.
- IDLE:
  - frame_ready=1 -> START_CD next cycle; err_code cleared to 0 on that edge.
- START_CD:
  - cd_start=1 for exactly this one cycle; timer<=0; -> WAIT_CD.
  - cd_done in this cycle is ignored.
- WAIT_CD:
  - cd_done=1 -> internal corner register captures cd_corners; -> CHECK.
  - Else timer++. When timer reaches TIMEOUT-1 with no done: err_code=1; -> IDLE.
  - If done arrives in the same cycle as the timeout, done wins.
- CHECK (one cycle, signed arithmetic at XW+1 / YW+1 bits):
  - Valid iff all hold:
    - tr_x-tl_x >= MIN_SPAN
    - br_x-bl_x >= MIN_SPAN
    - bl_y-tl_y >= MIN_SPAN
    - br_y-tr_y >= MIN_SPAN
  - Valid -> corners output updated from capture register; -> START_RECT.
  - Invalid -> corners unchanged; err_code=2; -> IDLE.
- START_RECT:
  - rect_start=1 for exactly one cycle; timer<=0; -> WAIT_RECT.
  - rect_done in this cycle is ignored.
- WAIT_RECT:
  - rect_done=1 -> good_count++ (wrap); -> IDLE.
  - Timeout rule identical to WAIT_CD, with err_code=3.
- busy is registered: high the cycle after frame_ready is accepted, low the cycle after returning to IDLE.
- Dropped frames:
  - frame_ready while state!=IDLE -> drop_count++ (saturating).
  - frame_ready in the same cycle the FSM enters IDLE is also dropped; it is accepted only while already in IDLE.
- corners is stable throughout a rectification; it changes only on the CHECK->START_RECT edge.
- cd_done or rect_done arriving outside its WAIT state is ignored and has no side effects.
- Latency: frame_ready (cycle 0) -> cd_start high at cycle 1. cd_done at cycle N -> rect_start high at cycle N+2.

Test Plan:
- Nominal:
  - Stimulus: reset, frame_ready at t0; cd_done at cycle 20 with TL(100,50) TR(500,60) BL(90,400) BR(520,410); rect_done 30 cycles after rect_start.
  - Required: cd_start high only at cycle 1; rect_start high only at cycle 22; corners equal the input set; err_code=0; good_count=1; busy falls after rect_done.
- Bad quad:
  - Stimulus: TR.x=110 with TL.x=100.
  - Required: err_code=2; no rect_start; corners retain the previous good set; busy low 1 cycle after CHECK.
- Detector timeout:
  - Stimulus: TIMEOUT=50, cd_done never asserted.
  - Required: err_code=1 and return to IDLE exactly 50 cycles after cd_start; no rect_start.
- Drops and saturation:
  - Stimulus: 300 frame_ready pulses during one WAIT_CD.
  - Required: drop_count=255. A later frame_ready in IDLE starts a new run and clears err_code.
- Async reset mid-run:
  - Stimulus: assert reset between clock edges during WAIT_RECT.
  - Required: all outputs go to reset values without waiting for a clock edge; a subsequent rect_done has no effect.
- Stray dones:
  - Stimulus: cd_done pulsed in IDLE and during START_CD.
  - Required: no state change, corners unchanged, no rect_start.

Source files
------------

// File: rtl/rectify_sequencer.sv
// Sequences corner detection, quad sanity check and rectification per frame; cd_start 1 cycle after frame_ready, rect_start 2 after cd_done.
// No backpressure: each done is awaited with a timeout, and frame_ready seen outside IDLE is counted as a drop.
module rectify_sequencer #(
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int TIMEOUT  = 1000000,
  parameter int MIN_SPAN = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_ready,
  output logic                  cd_start,
  input  logic                  cd_done,
  input  logic [4*(XW+YW)-1:0]  cd_corners,
  output logic                  rect_start,
  input  logic                  rect_done,
  output logic [4*(XW+YW)-1:0]  corners,
  output logic                  busy,
  output logic [1:0]            err_code,
  output logic [7:0]            good_count,
  output logic [7:0]            drop_count
);

  localparam int CW = XW + YW;
  localparam int NW = 4 * CW;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]        TLAST = TW'(TIMEOUT - 1);
  localparam logic signed [XW:0]   MIN_X = (XW + 1)'(MIN_SPAN);
  localparam logic signed [YW:0]   MIN_Y = (YW + 1)'(MIN_SPAN);

  typedef enum logic [2:0] {
    IDLE, START_CD, WAIT_CD, CHECK, START_RECT, WAIT_RECT
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d, timer_inc;
  logic [NW-1:0]   cap_q, cap_d, corners_q, corners_d;
  logic [1:0]      err_q, err_d;
  logic [7:0]      good_q, good_d, drop_q, drop_d;
  logic            busy_q, cd_start_q, rect_start_q;

  logic [XW-1:0]   tl_x, tr_x, bl_x, br_x;
  logic [YW-1:0]   tl_y, tr_y, bl_y, br_y;
  logic signed [XW:0] top_w, bot_w;
  logic signed [YW:0] left_h, right_h;
  logic            quad_ok;

  assign tl_x = cap_q[0*CW      +: XW];
  assign tl_y = cap_q[0*CW + XW +: YW];
  assign tr_x = cap_q[1*CW      +: XW];
  assign tr_y = cap_q[1*CW + XW +: YW];
  assign bl_x = cap_q[2*CW      +: XW];
  assign bl_y = cap_q[2*CW + XW +: YW];
  assign br_x = cap_q[3*CW      +: XW];
  assign br_y = cap_q[3*CW + XW +: YW];

  // One extra bit keeps inverted (negative-span) quads from wrapping into large positives.
  assign top_w   = $signed({1'b0, tr_x}) - $signed({1'b0, tl_x});
  assign bot_w   = $signed({1'b0, br_x}) - $signed({1'b0, bl_x});
  assign left_h  = $signed({1'b0, bl_y}) - $signed({1'b0, tl_y});
  assign right_h = $signed({1'b0, br_y}) - $signed({1'b0, tr_y});
  assign quad_ok = (top_w >= MIN_X) && (bot_w >= MIN_X) &&
                   (left_h >= MIN_Y) && (right_h >= MIN_Y);

  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cap_d     = cap_q;
    corners_d = corners_q;
    err_d     = err_q;
    good_d    = good_q;
    drop_d    = drop_q;

    if (frame_ready && (state_q != IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_ready) begin
          err_d   = 2'd0;
          state_d = START_CD;
        end
      end
      START_CD: begin
        timer_d = '0;
        state_d = WAIT_CD;
      end
      WAIT_CD: begin
        timer_d = timer_inc;
        if (cd_done) begin
          cap_d   = cd_corners;
          state_d = CHECK;
        end else if (timer_inc == TLAST) begin
          err_d   = 2'd1;
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (quad_ok) begin
          corners_d = cap_q;
          state_d   = START_RECT;
        end else begin
          err_d   = 2'd2;
          state_d = IDLE;
        end
      end
      START_RECT: begin
        timer_d = '0;
        state_d = WAIT_RECT;
      end
      WAIT_RECT: begin
        timer_d = timer_inc;
        if (rect_done) begin
          good_d  = good_q + 8'd1;
          state_d = IDLE;
        end else if (timer_inc == TLAST) begin
          err_d   = 2'd3;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      cap_q        <= '0;
      corners_q    <= '0;
      err_q        <= 2'd0;
      good_q       <= 8'd0;
      drop_q       <= 8'd0;
      busy_q       <= 1'b0;
      cd_start_q   <= 1'b0;
      rect_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cap_q        <= cap_d;
      corners_q    <= corners_d;
      err_q        <= err_d;
      good_q       <= good_d;
      drop_q       <= drop_d;
      busy_q       <= (state_d != IDLE);
      cd_start_q   <= (state_d == START_CD);
      rect_start_q <= (state_d == START_RECT);
    end
  end

  assign cd_start   = cd_start_q;
  assign rect_start = rect_start_q;
  assign corners    = corners_q;
  assign busy       = busy_q;
  assign err_code   = err_q;
  assign good_count = good_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_rectify_sequencer.sv
// Scenario bench for rectify_sequencer: two instances, a long-timeout one for the main flows
// and a TIMEOUT=50 one for the timeout boundaries; outcomes are queued at frame start and popped at run end.
module tb_rectify_sequencer;

  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int CW   = XW + YW;
  localparam int NW   = 4 * CW;
  localparam int TO_A = 1000;
  localparam int TO_B = 50;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          frame_ready = 1'b0, cd_done = 1'b0, rect_done = 1'b0;
  logic [NW-1:0] cd_corners = '0;
  logic          cd_start, rect_start, busy;
  logic [NW-1:0] corners;
  logic [1:0]    err_code;
  logic [7:0]    good_count, drop_count;

  logic          b_frame_ready = 1'b0, b_cd_done = 1'b0, b_rect_done = 1'b0;
  logic [NW-1:0] b_cd_corners = '0;
  logic          b_cd_start, b_rect_start, b_busy;
  logic [NW-1:0] b_corners;
  logic [1:0]    b_err_code;
  logic [7:0]    b_good_count, b_drop_count;

  rectify_sequencer #(.XW(XW), .YW(YW), .TIMEOUT(TO_A), .MIN_SPAN(16)) u_dut (
    .clk(clk), .reset(reset), .frame_ready(frame_ready), .cd_start(cd_start),
    .cd_done(cd_done), .cd_corners(cd_corners), .rect_start(rect_start),
    .rect_done(rect_done), .corners(corners), .busy(busy), .err_code(err_code),
    .good_count(good_count), .drop_count(drop_count)
  );

  rectify_sequencer #(.XW(XW), .YW(YW), .TIMEOUT(TO_B), .MIN_SPAN(16)) u_dut_to (
    .clk(clk), .reset(reset), .frame_ready(b_frame_ready), .cd_start(b_cd_start),
    .cd_done(b_cd_done), .cd_corners(b_cd_corners), .rect_start(b_rect_start),
    .rect_done(b_rect_done), .corners(b_corners), .busy(b_busy), .err_code(b_err_code),
    .good_count(b_good_count), .drop_count(b_drop_count)
  );

  typedef struct packed {
    logic [1:0]    err;
    logic [NW-1:0] crn;
    logic [7:0]    good;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [NW-1:0] quad_a, quad_b, quad_c;
  logic [NW-1:0] good_set   = '0;
  logic [7:0]    good_model = 8'd0;

  function automatic logic [NW-1:0] mk_quad(
    input logic [XW-1:0] tlx, input logic [YW-1:0] tly,
    input logic [XW-1:0] trx, input logic [YW-1:0] tr_y,
    input logic [XW-1:0] blx, input logic [YW-1:0] bly,
    input logic [XW-1:0] brx, input logic [YW-1:0] bry);
    return {bry, brx, bly, blx, tr_y, trx, tly, tlx};
  endfunction

  function automatic bit quad_valid(input logic [NW-1:0] q);
    int tlx, tly, trx, tr_y, blx, bly, brx, bry;
    tlx  = int'(q[0*CW +: XW]);  tly = int'(q[0*CW + XW +: YW]);
    trx  = int'(q[1*CW +: XW]);  tr_y = int'(q[1*CW + XW +: YW]);
    blx  = int'(q[2*CW +: XW]);  bly = int'(q[2*CW + XW +: YW]);
    brx  = int'(q[3*CW +: XW]);  bry = int'(q[3*CW + XW +: YW]);
    return (trx - tlx >= 16) && (brx - blx >= 16) && (bly - tly >= 16) && (bry - tr_y >= 16);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++;
    if ({cd_start, rect_start, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000", {cd_start, rect_start, busy});
    end
    checks++;
    if (corners !== '0) begin errors++; $display("FAIL reset_corners got=%h exp=0", corners); end
    checks++;
    if ({err_code, good_count, drop_count} !== 18'd0) begin
      errors++; $display("FAIL reset_status got=%0d/%0d/%0d exp=0/0/0", err_code, good_count, drop_count);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_nominal;
    logic [NW-1:0] prev;
    exp_t          e;
    prev = good_set;
    for (int c = 0; c <= 60; c++) begin
      frame_ready = (c == 0);
      cd_done     = (c == 20);
      rect_done   = (c == 52);
      cd_corners  = (c == 20) ? quad_a : quad_b;
      if (c == 0) begin
        e.err  = quad_valid(quad_a) ? 2'd0 : 2'd2;
        e.crn  = quad_a;
        e.good = good_model + 8'd1;
        sb_q.push_back(e);
        good_set = quad_a; good_model = good_model + 8'd1;
      end
      checks++;
      if (cd_start !== (c == 1)) begin errors++; $display("FAIL nom_cd_start c=%0d got=%b exp=%b", c, cd_start, c == 1); end
      checks++;
      if (rect_start !== (c == 22)) begin errors++; $display("FAIL nom_rect_start c=%0d got=%b exp=%b", c, rect_start, c == 22); end
      checks++;
      if (busy !== (c >= 1 && c <= 52)) begin errors++; $display("FAIL nom_busy c=%0d got=%b", c, busy); end
      checks++;
      if (corners !== ((c >= 22) ? quad_a : prev)) begin errors++; $display("FAIL nom_corners c=%0d got=%h", c, corners); end
      tick;
    end
    frame_ready = 1'b0; cd_done = 1'b0; rect_done = 1'b0;
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL nom_sb got=empty exp=entry"); end
    else begin
      e = sb_q.pop_front();
      checks += 2;
      if (err_code !== e.err) begin errors++; $display("FAIL nom_err got=%0d exp=%0d", err_code, e.err); end
      if (corners !== e.crn) begin errors++; $display("FAIL nom_crn got=%h exp=%h", corners, e.crn); end
      if (good_count !== e.good) begin errors++; $display("FAIL nom_good got=%0d exp=%0d", good_count, e.good); end
    end
  endtask

  task automatic test_bad_quad;
    exp_t e;
    for (int c = 0; c <= 12; c++) begin
      frame_ready = (c == 0);
      cd_done     = (c == 5);
      cd_corners  = quad_b;
      if (c == 0) begin
        e.err  = quad_valid(quad_b) ? 2'd0 : 2'd2;
        e.crn  = good_set;
        e.good = good_model;
        sb_q.push_back(e);
      end
      checks++;
      if (rect_start !== 1'b0) begin errors++; $display("FAIL bad_rect_start c=%0d got=1 exp=0", c); end
      checks++;
      if (busy !== (c >= 1 && c <= 6)) begin errors++; $display("FAIL bad_busy c=%0d got=%b", c, busy); end
      checks++;
      if (corners !== good_set) begin errors++; $display("FAIL bad_corners c=%0d got=%h exp=%h", c, corners, good_set); end
      tick;
    end
    frame_ready = 1'b0; cd_done = 1'b0;
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL bad_sb got=empty exp=entry"); end
    else begin
      e = sb_q.pop_front();
      checks += 2;
      if (err_code !== e.err) begin errors++; $display("FAIL bad_err got=%0d exp=%0d", err_code, e.err); end
      if (corners !== e.crn) begin errors++; $display("FAIL bad_crn got=%h exp=%h", corners, e.crn); end
      if (good_count !== e.good) begin errors++; $display("FAIL bad_good got=%0d exp=%0d", good_count, e.good); end
    end
  endtask

  task automatic test_stray_done;
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      cd_done    = (p == 0);
      rect_done  = (p == 2);
      cd_corners = quad_c;
      tick;
    end
    cd_done = 1'b0; rect_done = 1'b0;
    checks++;
    if ({busy, cd_start, rect_start} !== 3'b000) begin errors++; $display("FAIL stray_idle_ctrl got=%b exp=000", {busy, cd_start, rect_start}); end
    checks++;
    if (corners !== good_set) begin errors++; $display("FAIL stray_idle_corners got=%h exp=%h", corners, good_set); end
    checks++;
    if (good_count !== good_model) begin errors++; $display("FAIL stray_idle_good got=%0d exp=%0d", good_count, good_model); end
    for (int c = 0; c <= 20; c++) begin
      frame_ready = (c == 0);
      cd_done     = (c == 1) || (c == 10);
      rect_done   = (c == 1) || (c == 15);
      cd_corners  = quad_c;
      if (c == 0) begin
        e.err  = quad_valid(quad_c) ? 2'd0 : 2'd2;
        e.crn  = quad_c;
        e.good = good_model + 8'd1;
        sb_q.push_back(e);
        good_set = quad_c; good_model = good_model + 8'd1;
      end
      if (c == 1) begin
        checks++;
        if (err_code !== 2'd0) begin errors++; $display("FAIL stray_err_clear got=%0d exp=0", err_code); end
      end
      checks++;
      if (rect_start !== (c == 12)) begin errors++; $display("FAIL stray_rect_start c=%0d got=%b exp=%b", c, rect_start, c == 12); end
      checks++;
      if (busy !== (c >= 1 && c <= 15)) begin errors++; $display("FAIL stray_busy c=%0d got=%b", c, busy); end
      tick;
    end
    frame_ready = 1'b0; cd_done = 1'b0; rect_done = 1'b0;
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL stray_sb got=empty exp=entry"); end
    else begin
      e = sb_q.pop_front();
      checks += 2;
      if (err_code !== e.err) begin errors++; $display("FAIL stray_err got=%0d exp=%0d", err_code, e.err); end
      if (corners !== e.crn) begin errors++; $display("FAIL stray_crn got=%h exp=%h", corners, e.crn); end
      if (good_count !== e.good) begin errors++; $display("FAIL stray_good got=%0d exp=%0d", good_count, e.good); end
    end
  endtask

  task automatic test_drops;
    exp_t e;
    int   dm;
    dm = 0;
    for (int c = 0; c <= 1003; c++) begin
      frame_ready = (c == 0) || (c >= 2 && c <= 600 && c % 2 == 0) || (c == 1003);
      cd_done     = 1'b0;
      cd_corners  = quad_a;
      if (c == 0) begin
        e.err = 2'd1; e.crn = good_set; e.good = good_model;
        sb_q.push_back(e);
      end
      if (c == 101 || c == 700 || c == 1002) begin
        checks++;
        if (drop_count !== 8'(dm)) begin errors++; $display("FAIL drop_count c=%0d got=%0d exp=%0d", c, drop_count, dm); end
      end
      if (c == 1000) begin
        checks++;
        if (busy !== 1'b1 || err_code !== 2'd0) begin errors++; $display("FAIL drop_pre_timeout busy=%b err=%0d exp=1/0", busy, err_code); end
      end
      if (c == 1001) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drop_timeout_busy got=%b exp=0", busy); end
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL drop_sb got=empty exp=entry"); end
        else begin
          e = sb_q.pop_front();
          checks += 2;
          if (err_code !== e.err) begin errors++; $display("FAIL drop_err got=%0d exp=%0d", err_code, e.err); end
          if (corners !== e.crn) begin errors++; $display("FAIL drop_crn got=%h exp=%h", corners, e.crn); end
          if (good_count !== e.good) begin errors++; $display("FAIL drop_good got=%0d exp=%0d", good_count, e.good); end
        end
      end
      if (frame_ready && c >= 1 && c <= 1000 && dm < 255) dm++;
      tick;
    end
    frame_ready = 1'b0;
    checks++;
    if ({cd_start, busy, err_code} !== 4'b1100) begin
      errors++; $display("FAIL drop_restart cd_start=%b busy=%b err=%0d exp=1/1/0", cd_start, busy, err_code);
    end
  endtask

  task automatic test_async_reset;
    for (int d = 0; d < 10; d++) begin
      cd_done    = (d == 3);
      cd_corners = quad_c;
      tick;
    end
    cd_done = 1'b0;
    checks++;
    if (busy !== 1'b1 || corners !== quad_c || drop_count !== 8'd255) begin
      errors++; $display("FAIL arst_pre busy=%b drop=%0d exp busy=1 drop=255", busy, drop_count);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({cd_start, rect_start, busy} !== 3'b000) begin errors++; $display("FAIL arst_ctrl got=%b exp=000", {cd_start, rect_start, busy}); end
    checks++;
    if (corners !== '0) begin errors++; $display("FAIL arst_corners got=%h exp=0", corners); end
    checks++;
    if ({err_code, good_count, drop_count} !== 18'd0) begin
      errors++; $display("FAIL arst_status got=%0d/%0d/%0d exp=0/0/0", err_code, good_count, drop_count);
    end
    good_set = '0; good_model = 8'd0;
    #1;
    reset     = 1'b0;
    rect_done = 1'b1;
    tick;
    rect_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (good_count !== 8'd0 || busy !== 1'b0 || rect_start !== 1'b0) begin
        errors++; $display("FAIL arst_post k=%0d good=%0d busy=%b rect_start=%b exp=0/0/0", k, good_count, busy, rect_start);
      end
      tick;
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    for (int c = 0; c <= 55; c++) begin
      b_frame_ready = (c == 0) || (c == 50);
      b_cd_corners  = quad_a;
      if (c == 0) begin
        e.err = 2'd1; e.crn = '0; e.good = 8'd0;
        sb_q.push_back(e);
      end
      checks++;
      if (b_cd_start !== (c == 1)) begin errors++; $display("FAIL to_cd_start c=%0d got=%b exp=%b", c, b_cd_start, c == 1); end
      checks++;
      if (b_busy !== (c >= 1 && c <= 50)) begin errors++; $display("FAIL to_busy c=%0d got=%b", c, b_busy); end
      checks++;
      if (b_rect_start !== 1'b0) begin errors++; $display("FAIL to_rect_start c=%0d got=1 exp=0", c); end
      if (c == 50) begin
        checks++;
        if (b_err_code !== 2'd0) begin errors++; $display("FAIL to_err_early got=%0d exp=0", b_err_code); end
      end
      if (c == 51) begin
        checks++;
        if (b_drop_count !== 8'd1) begin errors++; $display("FAIL to_drop_edge got=%0d exp=1", b_drop_count); end
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL to_sb got=empty exp=entry"); end
        else begin
          e = sb_q.pop_front();
          checks += 2;
          if (b_err_code !== e.err) begin errors++; $display("FAIL to_err got=%0d exp=%0d", b_err_code, e.err); end
          if (b_corners !== e.crn) begin errors++; $display("FAIL to_crn got=%h exp=%h", b_corners, e.crn); end
          if (b_good_count !== e.good) begin errors++; $display("FAIL to_good got=%0d exp=%0d", b_good_count, e.good); end
        end
      end
      tick;
    end
    b_frame_ready = 1'b0;
  endtask

  task automatic test_done_wins;
    exp_t e;
    for (int c = 0; c <= 105; c++) begin
      b_frame_ready = (c == 0);
      b_cd_done     = (c == 50);
      b_cd_corners  = (c == 50) ? quad_a : quad_b;
      if (c == 0) begin
        e.err = 2'd3; e.crn = quad_a; e.good = 8'd0;
        sb_q.push_back(e);
      end
      if (c == 1 || c == 101) begin
        checks++;
        if (b_err_code !== 2'd0) begin errors++; $display("FAIL dw_err_mid c=%0d got=%0d exp=0", c, b_err_code); end
      end
      checks++;
      if (b_rect_start !== (c == 52)) begin errors++; $display("FAIL dw_rect_start c=%0d got=%b exp=%b", c, b_rect_start, c == 52); end
      checks++;
      if (b_busy !== (c >= 1 && c <= 101)) begin errors++; $display("FAIL dw_busy c=%0d got=%b", c, b_busy); end
      if (c == 102) begin
        checks++;
        if (b_drop_count !== 8'd1) begin errors++; $display("FAIL dw_drop got=%0d exp=1", b_drop_count); end
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL dw_sb got=empty exp=entry"); end
        else begin
          e = sb_q.pop_front();
          checks += 2;
          if (b_err_code !== e.err) begin errors++; $display("FAIL dw_err got=%0d exp=%0d", b_err_code, e.err); end
          if (b_corners !== e.crn) begin errors++; $display("FAIL dw_crn got=%h exp=%h", b_corners, e.crn); end
          if (b_good_count !== e.good) begin errors++; $display("FAIL dw_good got=%0d exp=%0d", b_good_count, e.good); end
        end
      end
      tick;
    end
    b_frame_ready = 1'b0; b_cd_done = 1'b0;
  endtask

  initial begin
    quad_a = mk_quad(100, 50, 500, 60, 90, 400, 520, 410);
    quad_b = mk_quad(100, 50, 110, 60, 90, 400, 520, 410);
    quad_c = mk_quad(200, 100, 300, 100, 200, 300, 300, 300);
    test_reset;
    test_nominal;
    test_bad_quad;
    test_stray_done;
    test_drops;
    test_async_reset;
    test_timeout;
    test_done_wins;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
